// File: rtl/axis_prbs_checker_pkg.sv
// Shared PRBS definitions: checker state encoding and the LFSR step used by
// both the generator and the checker.
package prbs_pkg;

  localparam int unsigned LFSR_MAX_W = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  // Galois-style step, width-generic via w; operands are zero-extended to LFSR_MAX_W.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] r;
    mask = (w >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
    r    = (s << 1) ^ (s[6'(w - 1)] ? poly : '0);
    return r & mask;
  endfunction

endpackage

// File: rtl/axis_prbs_checker_if.sv
// AXI-Stream beat bundle (data, valid, ready) between PRBS stages.
interface axis_prbs_checker_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/axis_prbs_checker_popcount.sv
// Combinational population count of a DATA_WIDTH-bit word.
module popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]          data_i,
  output logic [$clog2(W):0]    cnt_o
);
  localparam int PCW = $clog2(W) + 1;

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + PCW'(data_i[i]);
    end
  end
endmodule

// File: rtl/axis_prbs_checker.sv
// PRBS stream checker: self-synchronising lock/loss FSM with saturating counters.
// Define AXIS_PRBS_CHK_BITERR_EN to count bit errors instead of word errors.
//   state  | meaning
//   HUNT   | re-seed from every received word, count consecutive predicted matches
//   LOCKED | free-running prediction, count errors and words, watch for loss
module axis_prbs_checker
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_CNT   = 8,
  parameter int LOSS_CNT   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] poly_i,
  input  logic                  clear_i,
  axis_prbs_checker_if.slave    s_axis,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);
  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int LCW = $clog2(LOSS_CNT + 1);
  localparam int PCW = $clog2(DATA_WIDTH) + 1;
  localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;

  prbs_state_e           state_q, state_d;
  logic                  seeded_q, seeded_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [MCW-1:0]        match_q, match_d;
  logic [LCW-1:0]        miss_q, miss_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic                  beat;
  logic [DATA_WIDTH-1:0] nxt_ref, nxt_data, nxt_exp;
  logic [MCW-1:0]        match_inc;
  logic [LCW-1:0]        miss_inc;
  logic [SW-1:0]         inc_w, err_sum;
  logic [CNT_WIDTH:0]    word_sum;

  assign s_axis.tready = ~rst_i;
  assign beat          = s_axis.tvalid & s_axis.tready;

  assign nxt_ref  = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(ref_q), LFSR_MAX_W'(poly_i), DATA_WIDTH));
  assign nxt_data = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(s_axis.tdata), LFSR_MAX_W'(poly_i), DATA_WIDTH));
  assign nxt_exp  = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(poly_i), DATA_WIDTH));

  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

`ifdef AXIS_PRBS_CHK_BITERR_EN
  logic [PCW-1:0] bit_errs;
  popcount #(.W(DATA_WIDTH)) u_popcount (
    .data_i (s_axis.tdata ^ exp_q),
    .cnt_o  (bit_errs)
  );
  assign inc_w = SW'(bit_errs);
`else
  assign inc_w = SW'(1);
`endif

  assign err_sum  = SW'(err_cnt_q) + inc_w;
  assign word_sum = {1'b0, word_cnt_q} + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      seeded_q   <= 1'b0;
      ref_q      <= '0;
      exp_q      <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      ref_q      <= ref_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seeded_d   = seeded_q;
    ref_d      = ref_q;
    exp_d      = exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;

    if (beat) begin
      if (state_q == HUNT) begin
        ref_d = s_axis.tdata;
        if (!seeded_q) begin
          seeded_d = 1'b1;
          match_d  = '0;
        end else if (s_axis.tdata == nxt_ref) begin
          match_d = match_inc;
          if (match_inc == MCW'(LOCK_CNT)) begin
            state_d = LOCKED;
            exp_d   = nxt_data;
            miss_d  = '0;
          end
        end else begin
          match_d = '0;
        end
      end else begin
        exp_d      = nxt_exp;
        word_cnt_d = word_sum[CNT_WIDTH] ? '1 : word_sum[CNT_WIDTH-1:0];
        if (s_axis.tdata != exp_q) begin
          err_d     = 1'b1;
          err_cnt_d = (err_sum > SW'({CNT_WIDTH{1'b1}})) ? '1 : CNT_WIDTH'(err_sum);
          miss_d    = miss_inc;
          if (miss_inc == LCW'(LOSS_CNT)) begin
            state_d  = HUNT;
            seeded_d = 1'b0;
          end
        end else begin
          miss_d = '0;
        end
      end
    end

    if (clear_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: doc/axis_prbs_checker.md
# axis_prbs_checker

Consumes the AXI-Stream word sequence produced by the LFSR generator stage and checks it against a locally predicted sequence. It self-synchronises to the incoming stream, declares lock after a programmable run of correct words, then counts word (or bit) errors and drops lock after a run of consecutive misses. It sits directly downstream of the LFSR/CRC generator stage in loopback and link-test paths.

## Interface
- DATA_WIDTH, 16: stream word width; also the LFSR state width.
- LOCK_CNT, 8: consecutive correct words needed to enter LOCKED.
- LOSS_CNT, 4: consecutive wrong words in LOCKED that force return to HUNT.
- CNT_WIDTH, 32: width of the error and word counters.

Ports:
- clk_i  in  1  single clock; all logic is synchronous to its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- poly_i  in  DATA_WIDTH  feedback polynomial; must match the generator and be static while not in reset.
- clear_i  in  1  synchronous clear of err_cnt_o and word_cnt_o; state and lock are unaffected.
- s_axis_tdata  in  DATA_WIDTH  received word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  equals ~rst_i; the block never back-pressures.
- locked_o  out  1  high in state LOCKED.
- err_o  out  1  one-cycle pulse for each mismatching beat accepted in LOCKED.
- err_cnt_o  out  CNT_WIDTH  saturating error count.
- word_cnt_o  out  CNT_WIDTH  saturating count of beats accepted in LOCKED.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready. Cycles without an accepted beat change nothing.
- Prediction uses lfsr_next(s, poly). One step is {s[W-2:0],1'b0} ^ (s[W-1] ? poly : '0). This is the same step function the generator uses per valid word.
- State HUNT (reset state):
  - The first beat after entering HUNT loads ref_q <= tdata and clears match_cnt.
  - Each following beat: if tdata == lfsr_next(ref_q), match_cnt increments; otherwise match_cnt <= 0.
  - ref_q <= tdata on every beat, so the checker re-seeds from the received data.
  - When match_cnt would reach LOCK_CNT: go to LOCKED, set exp_q <= lfsr_next(tdata), clear miss_cnt.
- State LOCKED:
  - Prediction free-runs and is never re-seeded: each beat sets exp_q <= lfsr_next(exp_q).
  - Match: miss_cnt <= 0.
  - Mismatch: err_o pulses, err_cnt increments, miss_cnt increments.
  - word_cnt increments on every beat.
  - When miss_cnt would reach LOSS_CNT: go to HUNT. The ref-load on the next beat restarts acquisition.
- Counters saturate at all-ones and never wrap.
- When clear_i coincides with an increment, clear wins: the result is 0.
- Beats in HUNT never touch err_cnt_o or word_cnt_o.
- An all-zero input word is a legal value. With a nonzero poly, a stuck-zero stream does lock, because lfsr_next(0)=0; that outcome is documented and not filtered.

## Timing
- Reset values: s_axis_tready=0 during reset; locked_o=0, err_o=0, err_cnt_o=0, word_cnt_o=0, state=HUNT, all internal counters 0.
- An rst_i asserted mid-stream takes effect at the next edge and discards lock and all counts.
- err_o, counters and locked_o are registered. They update on the edge that accepts the beat and are visible the following cycle (latency 1).
- Lock is acquired on the edge accepting the (LOCK_CNT+1)-th beat after entering HUNT: one seed beat plus LOCK_CNT matching beats.
- Loss occurs on the edge accepting the LOSS_CNT-th consecutive bad beat. That beat still pulses err_o and counts as an error.
- Back-to-back beats at full rate are supported; throughput is one word per cycle.

## Configuration
- AXIS_PRBS_CHK_BITERR_EN defined: on a LOCKED mismatch, err_cnt_o adds popcount(tdata ^ exp_q), saturating, so it counts bit errors.
- Not defined: err_cnt_o adds 1 per mismatching word, so it counts word errors.
- err_o, lock/loss behaviour and word_cnt_o are identical in both builds.

## Structure
- Package prbs_pkg holds:
  - typedef enum {HUNT, LOCKED} for the state.
  - function lfsr_next, parameterised by width through its arguments. The generator side reuses it so both sides share one definition.
- Sub-module popcount (DATA_WIDTH in, $clog2(DATA_WIDTH)+1 out), combinational. It is instantiated only under AXIS_PRBS_CHK_BITERR_EN.

## Test plan
- Generator-fed clean stream with poly=16'hB400, seed=16'h0001, 20 beats, LOCK_CNT=8 -> locked_o rises the cycle after beat 9; err_cnt_o=0; word_cnt_o=11 after beat 20.
- Locked stream, flip bit 0 of one word -> one err_o pulse; err_cnt_o=1 (and 1 under BITERR_EN); lock held. Repeat with 3 flipped bits under BITERR_EN -> err_cnt_o increases by 3.
- Locked stream, then 4 consecutive corrupted words with LOSS_CNT=4 -> err_cnt_o=4; locked_o falls after the 4th; relock after 9 further clean beats.
- Random-gap tvalid (about 50 % duty) over the clean stream -> same lock point in beats; no errors; s_axis_tready stays high.
- HUNT with a mismatch at beat 5 -> match_cnt restarts; lock only after 8 consecutive matches following the bad beat.
- Preload err_cnt_o near saturation (CNT_WIDTH=4, 17 errors) -> err_cnt_o holds 4'hF. Then clear_i together with an error -> 0. Then rst_i mid-stream -> all outputs at reset values and state HUNT.
